// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase timer.
//   phase_e : controller phase encoding (also the duration-table address)
//   state_e : timer FSM states
//   DEF_*   : default phase lengths in clock cycles
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_OFF    = 2'b00,
        PH_RED    = 2'b01,
        PH_GREEN  = 2'b10,
        PH_YELLOW = 2'b11
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_DONE  = 2'b10,
        ST_HOLD  = 2'b11
    } state_e;

    localparam int DEF_RED_DELAY    = 20000000;
    localparam int DEF_GREEN_DELAY  = 30000000;
    localparam int DEF_YELLOW_DELAY = 5000000;
    localparam int DEF_PED_CAP      = 5000000;
    localparam int DEF_CW           = 32;

endpackage

// File: rtl/phase_dur_table.sv
// Three-entry phase duration register file (red, green, yellow).
//   clk, reset : clock, asynchronous active-high reset (restores defaults)
//   we, waddr, wdata : write port; address 00 is not backed by storage
//   raddr, rdata     : combinational read port; address 00 reads 0
// A read and a write of the same entry on one edge returns the old value,
// because rdata comes straight from the registers.
module phase_dur_table
    import traffic_pkg::*;
#(
    parameter int CW           = DEF_CW,
    parameter int RED_DELAY    = DEF_RED_DELAY,
    parameter int GREEN_DELAY  = DEF_GREEN_DELAY,
    parameter int YELLOW_DELAY = DEF_YELLOW_DELAY
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [1:0]    waddr,
    input  logic [CW-1:0] wdata,
    input  logic [1:0]    raddr,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] red_q, red_d;
    logic [CW-1:0] green_q, green_d;
    logic [CW-1:0] yellow_q, yellow_d;

    always_comb begin
        red_d    = red_q;
        green_d  = green_q;
        yellow_d = yellow_q;
        if (we) begin
            case (waddr)
                PH_RED:    red_d    = wdata;
                PH_GREEN:  green_d  = wdata;
                PH_YELLOW: yellow_d = wdata;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red_q    <= CW'(RED_DELAY);
            green_q  <= CW'(GREEN_DELAY);
            yellow_q <= CW'(YELLOW_DELAY);
        end else begin
            red_q    <= red_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
        end
    end

    always_comb begin
        case (raddr)
            PH_RED:    rdata = red_q;
            PH_GREEN:  rdata = green_q;
            PH_YELLOW: rdata = yellow_q;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer for a traffic-light controller. Counts down the duration of
// the current phase and pulses phase_done when it expires.
//   clk, reset   : clock, asynchronous active-high reset
//   phase        : current controller phase (00 off, 01 red, 10 green, 11 yellow)
//   cfg_we/addr/data : duration-table write port
//   ped_req      : pedestrian button (level or pulse)
//   phase_done   : one-cycle pulse, registered
//   remaining    : cycles left in the current phase
//   busy         : counting in progress
//   ped_pending  : latched pedestrian request outstanding
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int RED_DELAY    = DEF_RED_DELAY,
    parameter int GREEN_DELAY  = DEF_GREEN_DELAY,
    parameter int YELLOW_DELAY = DEF_YELLOW_DELAY,
    parameter int PED_CAP      = DEF_PED_CAP,
    parameter int CW           = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    phase,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    input  logic          ped_req,
    output logic          phase_done,
    output logic [CW-1:0] remaining,
    output logic          busy,
    output logic          ped_pending
);

    localparam logic [CW-1:0] CAP = CW'(PED_CAP);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          done_q, done_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] dur_rd;
    logic          ped_eff;

    phase_dur_table #(
        .CW          (CW),
        .RED_DELAY   (RED_DELAY),
        .GREEN_DELAY (GREEN_DELAY),
        .YELLOW_DELAY(YELLOW_DELAY)
    ) u_dur (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (phase),
        .rdata (dur_rd)
    );

    // A button press on the current edge already counts toward the green
    // cap, so the shortening takes effect on the same edge it is latched.
    assign ped_eff = pend_q | ped_req;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        phase_d = phase;
        if (phase == PH_OFF) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else if (phase != phase_q) begin
            // Zero-length entries still run one cycle so phase_done fires.
            state_d = ST_COUNT;
            rem_d   = (dur_rd == '0) ? ONE : dur_rd;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (phase == PH_GREEN && ped_eff && rem_q > CAP) begin
                        rem_d = CAP;
                    end else if (rem_q <= ONE) begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        rem_d = rem_q - ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_HOLD;
                    rem_d   = '0;
                end
                default: ;
            endcase
        end

        done_d = (state_d == ST_DONE);

        // Clear on the end of a green phase; a press on that same edge wins.
        pend_d = pend_q;
        if (state_d == ST_DONE && state_q != ST_DONE && phase == PH_GREEN)
            pend_d = 1'b0;
        if (ped_req)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_OFF;
            rem_q   <= '0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign phase_done  = done_q;
    assign remaining   = rem_q;
    assign busy        = (state_q == ST_COUNT);
    assign ped_pending = pend_q;

endmodule

// File: doc/traffic_phase_timer.md
TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

Interface
REQ-001 The block SHALL have a parameter RED_DELAY, default 20000000, giving red phase length in clk cycles.
REQ-002 The block SHALL have a parameter GREEN_DELAY, default 30000000, giving green phase length in clk cycles.
REQ-003 The block SHALL have a parameter YELLOW_DELAY, default 5000000, giving yellow phase length in clk cycles.
REQ-004 The block SHALL have a parameter PED_CAP, default 5000000, giving the maximum green cycles left once a pedestrian request is pending.
REQ-005 The block SHALL have a parameter CW, default 32, giving the counter and duration width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port phase, input, 2 bits: current controller phase, encoded 01 red, 10 green, 11 yellow, 00 off.
REQ-009 The block SHALL have port cfg_we, input, 1 bit: duration-table write strobe.
REQ-010 The block SHALL have port cfg_addr, input, 2 bits: table index, which uses the same encoding as phase.
REQ-011 The block SHALL have port cfg_data, input, CW bits: the new duration value.
REQ-012 The block SHALL have port ped_req, input, 1 bit: pedestrian button, level or pulse.
REQ-013 The block SHALL have port phase_done, output, 1 bit: one-cycle pulse telling the controller to advance.
REQ-014 The block SHALL have port remaining, output, CW bits: cycles left in the current phase.
REQ-015 The block SHALL have port busy, output, 1 bit: high while counting.
REQ-016 The block SHALL have port ped_pending, output, 1 bit: a latched pedestrian request is outstanding.

Function
REQ-017 The FSM SHALL have states IDLE, COUNT, DONE and HOLD, with phase_q holding phase registered one cycle.
REQ-018 On any edge where phase != phase_q and phase != 00, the FSM SHALL go to COUNT and load remaining <= max(dur[phase],1), from any state.
REQ-019 On any edge where phase == 00, the FSM SHALL go to IDLE with remaining <= 0, which takes priority over REQ-018.
REQ-020 In COUNT, remaining SHALL decrement by 1 per edge; at the edge where remaining == 1, remaining <= 0 and the FSM goes to DONE.
REQ-021 phase_done SHALL be a registered output that is high exactly in the DONE cycle, i.e. N edges after the load edge for duration N.
REQ-022 DONE SHALL last one cycle and then go to HOLD, where remaining stays 0 until phase changes per REQ-018 or REQ-019.
REQ-023 busy SHALL equal (state == COUNT).
REQ-024 A cfg_we write SHALL update dur[cfg_addr] at the edge; writes to address 00 are ignored.
REQ-025 A cfg_we write SHALL affect only later loads and SHALL NOT change a count in progress.
REQ-026 A write and a load of the same entry on the same edge SHALL load the old value.
REQ-027 ped_req high at any edge SHALL set ped_pending.
REQ-028 ped_pending SHALL clear on the edge that enters DONE while phase == 10; if a set and a clear fall on the same edge, the set wins.
REQ-029 In COUNT with phase == 10 and ped_pending, if remaining > PED_CAP then remaining <= PED_CAP on that edge instead of decrementing; otherwise the normal decrement applies.
REQ-030 Counter arithmetic SHALL be unsigned CW-bit and SHALL never wrap below 0.

Reset
REQ-031 Asserting reset SHALL immediately force state IDLE, phase_q=00, remaining=0, phase_done=0, busy=0, ped_pending=0.
REQ-032 Asserting reset SHALL restore the table to dur[01]=RED_DELAY, dur[10]=GREEN_DELAY, dur[11]=YELLOW_DELAY.
REQ-033 Reset during COUNT SHALL abort the count without any phase_done pulse.
REQ-034 After reset is released, the first nonzero phase SHALL be treated as a phase change.

Structure
REQ-035 The package traffic_pkg SHALL hold the phase encodings (PH_OFF, PH_RED, PH_GREEN, PH_YELLOW), the FSM state typedef, and the default delay constants.
REQ-036 The three-entry duration register file with its reset defaults SHALL be the sub-module phase_dur_table, with one write port and one combinational read port.

Verification (RED=4, GREEN=6, YELLOW=2, PED_CAP=3)
REQ-037 The bench SHALL check: phase 00 -> 01 -> remaining 4,3,2,1,0 with phase_done high in the cycle remaining reads 0, then HOLD with phase_done=0.
REQ-038 The bench SHALL check: phase 10 with ped_req pulsed while remaining=5 -> next remaining=3, phase_done after 3 more edges, ped_pending cleared.
REQ-039 The bench SHALL check: cfg write dur[11]=7 during a yellow count -> the current count is unchanged and the next yellow loads 7.
REQ-040 The bench SHALL check: a phase change 01 -> 11 mid-count at remaining=2 -> reload to 2, with no phase_done for the aborted red.
REQ-041 The bench SHALL check: cfg_data=0 written to dur[01] -> a red load gives remaining=1 and phase_done after 1 edge.
REQ-042 The bench SHALL check: reset asserted mid-COUNT between edges -> all outputs are 0 immediately and the table is back to 4/6/2.
